// File: rtl/multu_unit.sv
// Iterative unsigned multiplier in the EX stage, one product bit per cycle.
//
// A job starts when a valid instruction in EX carries the MULTU control code
// and the unit is idle. Operands are latched when the job is accepted. The
// product register starts as {0, multiplier}. Each BUSY cycle adds the
// multiplicand to the upper half when the current LSB is set, then shifts
// right by one. The carry out of the add is shifted into the product, so it
// is not lost. After WIDTH steps the product is written to HI/LO and done
// pulses for one cycle.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset; any in-flight multiply is dropped
//   ALUctrl ALU control code from the ALU controller
//   en      instruction in EX is valid (not a bubble)
//   opA     multiplicand (rs)
//   opB     multiplier (rt)
//   stall   combinational; freezes PC/IF/ID/EX while a multiply is accepted
//           or running
//   done    registered one-cycle pulse; HI/LO were just updated
//   hi      HI register, product[2*WIDTH-1:WIDTH]
//   lo      LO register, product[WIDTH-1:0]
module multu_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [5:0]  CTRL_MULTU = 6'h13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       ALUctrl,
  input  logic             en,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 start;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   p_shift;

  // Only IDLE may accept: the stalled MULTU is still on the inputs during DONE.
  assign start = en && (ALUctrl == CTRL_MULTU) && (state_q == StIdle);

  // WIDTH+1 bits so the carry becomes the new MSB after the shift.
  assign sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]}
                 + (p_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign p_shift = {sum, p_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    stall   = start || (state_q == StBusy);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = opA;
          p_d     = {{WIDTH{1'b0}}, opB};
          cnt_d   = CntW'(WIDTH - 1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        p_d = p_shift;
        if (cnt_q == '0) begin
          hi_d    = p_shift[2*WIDTH-1:WIDTH];
          lo_d    = p_shift[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      p_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/multu_unit.md
Name: multu_unit

Overview:
- Iterative unsigned multiplier in the EX stage, directly downstream of the ALU controller.
- Consumes the 6-bit ALU control code and accepts a job when the code is MULTU (6'h13).
- Computes the 64-bit product of the two register operands one bit per cycle and writes it to the HI/LO registers.
- Stalls the pipeline while busy. HI/LO feed the MFHI/MFLO path (ALU control code 0x0, pass-through).

Parameters:
WIDTH  32  operand width; product is 2*WIDTH bits
CTRL_MULTU  6'h13  ALU control code that starts a multiply

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
ALUctrl  input  6  ALU control code from the ALU controller
en  input  1  instruction in EX is valid (not a bubble)
opA  input  WIDTH  multiplicand (rs)
opB  input  WIDTH  multiplier (rt)
stall  output  1  freeze PC/IF/ID/EX registers (combinational)
done  output  1  one-cycle pulse: HI/LO just updated
hi  output  WIDTH  HI register (product[2W-1:W])
lo  output  WIDTH  LO register (product[W-1:0])

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, counter=0, product register=0, hi=0, lo=0, done=0.
  - An in-flight multiply is discarded and HI/LO are not written.
- States: IDLE, BUSY, DONE.
- start = en && (ALUctrl == CTRL_MULTU) && state==IDLE.
- stall = start || state==BUSY.
  - stall is combinational, so it is high in the accept cycle itself.
  - stall is low in DONE.
- IDLE:
  - On start, at the clock edge: latch A=opA; P={WIDTH'b0, opB}; cnt=WIDTH-1; go to BUSY.
  - Otherwise stay in IDLE. hi and lo hold.
- BUSY, each cycle:
  - sum = P[2W-1:W] + (P[0] ? A : 0), computed WIDTH+1 bits wide (keep the carry).
  - P <= {sum, P[W-1:1]}.
  - If cnt==0: write hi<=next P[2W-1:W], lo<=next P[W-1:0], and go to DONE.
  - Else cnt<=cnt-1.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - start is NOT evaluated in DONE. The stalled MULTU is still presented on ALUctrl/en this cycle and must not restart.
  - The pipeline advances at the end of the DONE cycle.
- Latency, with the accept cycle counted as cycle 0:
  - BUSY occupies cycles 1..WIDTH.
  - stall is high for cycles 0..WIDTH (WIDTH+1 cycles).
  - done=1 and new hi/lo are visible in cycle WIDTH+1.
- Operands are latched at accept. Changes on opA/opB during BUSY have no effect.
- Non-MULTU codes, or en=0: no state change, stall=0, hi/lo hold.
- Back-to-back MULTU: the second instruction reaches EX in the cycle after DONE (state IDLE) and starts normally. HI/LO are overwritten at its completion.
- done and hi/lo are registered outputs. stall is the only combinational output.
- Arithmetic is pure unsigned. No overflow is possible: the product fits in 2*WIDTH bits.

Test Plan:
- Reset, then opA=3, opB=5, ALUctrl=0x13, en=1:
  - stall=1 for 33 cycles starting at the accept cycle.
  - done pulses in cycle 33 with hi=0x00000000, lo=0x0000000F.
- opA=opB=0xFFFFFFFF, MULTU: hi=0xFFFFFFFE, lo=0x00000001. Checks the carry bit is preserved.
- opA=0x12345678, opB=0x9ABCDEF0; toggle opA/opB randomly during BUSY:
  - result is hi=0x0B00EA4E, lo=0x242D2080 (operands latched at accept);
  - en held high through DONE causes no restart.
- Non-MULTU traffic: ALUctrl=0x02 with en=1, or ALUctrl=0x13 with en=0 → stall=0, done=0, hi/lo unchanged from the prior result.
- Assert reset at cycle 10 of BUSY → stall=0, hi=lo=0, state IDLE immediately. A fresh MULTU of 7*6 then gives lo=42 after the full 33-cycle stall.
- Two consecutive MULTUs (2*3, then 0x10000*0x10000) → done pulses 34 cycles apart:
  - first result lo=6;
  - final result hi=0x00000001, lo=0x00000000.
